// File: rtl/access_pkg.sv
// Shared definitions for the access-panel session controller.
// Holds the user and function code constants and the controller state
// encoding. It is imported by the controller and by the permission lookup.
package access_pkg;

    // User codes that own at least one permission. Every other user code
    // is known to the panel but is refused everything.
    localparam logic [2:0] USR_OPERATOR   = 3'b001;
    localparam logic [2:0] USR_SUPERVISOR = 3'b011;
    localparam logic [2:0] USR_ADMIN      = 3'b101;
    localparam logic [2:0] USR_SERVICE    = 3'b110;

    // Function code meaning "no function". It is never granted and is the
    // value presented on active_func whenever no session is open.
    localparam logic [2:0] FN_NONE = 3'b000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        GRANTED = 3'd2,
        DENIED  = 3'd3,
        LOCKED  = 3'd4
    } state_t;

endpackage

// File: rtl/access_session_ctrl_perm_table.sv
// perm_table: purely combinational user/function permission lookup.
// Ports:
//   user         in  3  requesting user code
//   func         in  3  requested function code
//   granted_func out 3  func when the user may run it, FN_NONE otherwise
module perm_table
    import access_pkg::*;
(
    input  logic [2:0] user,
    input  logic [2:0] func,
    output logic [2:0] granted_func
);

    // One bit per function code; bit n set means function n is allowed.
    logic [7:0] allowed;

    always_comb begin
        allowed = 8'h00;
        case (user)
            USR_OPERATOR:   allowed = 8'b0101_1010; // 001,011,100,110
            USR_SUPERVISOR: allowed = 8'b0101_1110; // 001,010,011,100,110
            USR_ADMIN:      allowed = 8'b1111_1110; // 001..111
            USR_SERVICE:    allowed = 8'b0100_0010; // 001,110
            default:        allowed = 8'h00;
        endcase
        // FN_NONE is refused for every user, whatever the table says.
        allowed[0] = 1'b0;
    end

    assign granted_func = allowed[func] ? func : FN_NONE;

endmodule

// File: rtl/access_session_ctrl.sv
// access_session_ctrl: sequences the user/function permission check for the
// access panel, opens a timed session for granted functions and locks the
// panel out after MAX_FAILS consecutive denials.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid         request present, taken only while req_ready=1
//   user_id, func_req request contents, latched on acceptance
//   logout            closes an open session (level)
//   req_ready         controller idle and able to accept a request
//   session_active    a granted session is open
//   active_func       granted function, FN_NONE when no session
//   denied            one-cycle pulse: request refused
//   session_expired   one-cycle pulse: session closed by timeout
//   locked            lockout in progress
//   fail_count        consecutive denials so far
module access_session_ctrl
    import access_pkg::*;
#(
    parameter int SESSION_CYCLES = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCK_CYCLES    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] user_id,
    input  logic [2:0] func_req,
    input  logic       logout,
    output logic       req_ready,
    output logic       session_active,
    output logic [2:0] active_func,
    output logic       denied,
    output logic       session_expired,
    output logic       locked,
    output logic [1:0] fail_count
);

    // fail_count is only two bits wide, so the threshold must fit in it.
    if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_bad_max_fails
        $error("access_session_ctrl: MAX_FAILS must be in 1..3");
    end
    if (SESSION_CYCLES < 1 || LOCK_CYCLES < 1) begin : g_bad_cycles
        $error("access_session_ctrl: SESSION_CYCLES and LOCK_CYCLES must be >= 1");
    end

    // The session and lockout timers are never active together, so they
    // share one down-counter sized for the longer of the two.
    localparam int CNT_MAX = (SESSION_CYCLES > LOCK_CYCLES) ? SESSION_CYCLES : LOCK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SESS_LOAD = CNT_W'(SESSION_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAILS);

    state_t           state_q, state_d;
    logic [2:0]       user_q, user_d;
    logic [2:0]       func_q, func_d;
    logic [2:0]       active_func_q, active_func_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fail_count_q, fail_count_d;
    logic             session_expired_q, session_expired_d;
    logic [1:0]       fail_next;
    logic [2:0]       granted_func;

    // Only the latched request is looked up, so input changes after
    // acceptance cannot influence the decision.
    perm_table u_perm_table (
        .user         (user_q),
        .func         (func_q),
        .granted_func (granted_func)
    );

    always_comb begin
        state_d           = state_q;
        user_d            = user_q;
        func_d            = func_q;
        active_func_d     = active_func_q;
        cnt_d             = cnt_q;
        fail_count_d      = fail_count_q;
        session_expired_d = 1'b0;
        fail_next         = (fail_count_q == FAIL_MAX) ? fail_count_q : fail_count_q + 2'd1;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    user_d  = user_id;
                    func_d  = func_req;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // A refused lookup returns FN_NONE, so loading it
                // unconditionally keeps active_func at FN_NONE on denial.
                active_func_d = granted_func;
                if (granted_func != FN_NONE) begin
                    state_d      = GRANTED;
                    cnt_d        = SESS_LOAD;
                    fail_count_d = 2'd0;
                end else begin
                    state_d = DENIED;
                end
            end
            GRANTED: begin
                // logout wins over a simultaneous timeout: no expired pulse.
                if (logout) begin
                    state_d       = IDLE;
                    active_func_d = FN_NONE;
                end else if (cnt_q == '0) begin
                    state_d           = IDLE;
                    active_func_d     = FN_NONE;
                    session_expired_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DENIED: begin
                fail_count_d = fail_next;
                if (fail_next == FAIL_MAX) begin
                    state_d = LOCKED;
                    cnt_d   = LOCK_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    fail_count_d = 2'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            user_q            <= 3'd0;
            func_q            <= 3'd0;
            active_func_q     <= FN_NONE;
            cnt_q             <= '0;
            fail_count_q      <= 2'd0;
            session_expired_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            user_q            <= user_d;
            func_q            <= func_d;
            active_func_q     <= active_func_d;
            cnt_q             <= cnt_d;
            fail_count_q      <= fail_count_d;
            session_expired_q <= session_expired_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign session_active  = (state_q == GRANTED);
    assign denied          = (state_q == DENIED);
    assign locked          = (state_q == LOCKED);
    assign active_func     = active_func_q;
    assign fail_count      = fail_count_q;
    assign session_expired = session_expired_q;

endmodule

// File: tb/tb_access_session_ctrl.sv
// Testbench for access_session_ctrl: directed scenarios followed by random
// requests, each checked against a transaction-level model of the panel.
module tb_access_session_ctrl;

    localparam int SESS = 16;
    localparam int MAXF = 3;
    localparam int LOCK = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] user_id;
    logic [2:0] func_req;
    logic       logout;
    logic       req_ready;
    logic       session_active;
    logic [2:0] active_func;
    logic       denied;
    logic       session_expired;
    logic       locked;
    logic [1:0] fail_count;

    int checks_total = 0;
    int checks_passed = 0;
    int model_fails = 0;

    access_session_ctrl #(
        .SESSION_CYCLES (SESS),
        .MAX_FAILS      (MAXF),
        .LOCK_CYCLES    (LOCK)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .user_id         (user_id),
        .func_req        (func_req),
        .logout          (logout),
        .req_ready       (req_ready),
        .session_active  (session_active),
        .active_func     (active_func),
        .denied          (denied),
        .session_expired (session_expired),
        .locked          (locked),
        .fail_count      (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            checks_passed++;
    endtask

    // Permission rules written as explicit allowed lists per user.
    function automatic bit ref_grant(input logic [2:0] u, input logic [2:0] f);
        if (f == 3'd0) return 1'b0;
        case (u)
            3'd1:    return f inside {3'd1, 3'd3, 3'd4, 3'd6};
            3'd3:    return f inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
            3'd5:    return 1'b1;
            3'd6:    return f inside {3'd1, 3'd6};
            default: return 1'b0;
        endcase
    endfunction

    // Pull reset at the current negedge, verify the asynchronous clear,
    // release one cycle later and return at the following negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        logout = 1'b0;
        #1;
        chk("rst_sess_active", 32'(session_active), 32'd0);
        chk("rst_active_func", 32'(active_func), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_denied", 32'(denied), 32'd0);
        chk("rst_expired", 32'(session_expired), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_fails = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_fail_count", 32'(fail_count), 32'd0);
    endtask

    // One complete request transaction, started and ended at a negedge with
    // the controller idle. logout_at: index of the granted cycle on which
    // logout is raised (-1 none). abort_at: index of the granted or locked
    // cycle on which reset is pulled (-1 none).
    task automatic do_req(input logic [2:0] u, input logic [2:0] f,
                          input int logout_at, input int abort_at);
        bit grant;
        bit exp_expired;
        int n;
        grant = ref_grant(u, f);
        $display("req user=%0d func=%0d expect=%s logout_at=%0d abort_at=%0d fails_before=%0d",
                 u, f, grant ? "grant" : "deny", logout_at, abort_at, model_fails);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        user_id   = u;
        func_req  = f;
        @(negedge clk);
        req_valid = 1'b0;
        user_id   = 3'($urandom);
        func_req  = 3'($urandom);
        chk("ready_in_check", 32'(req_ready), 32'd0);
        chk("no_session_in_check", 32'(session_active), 32'd0);
        @(negedge clk);
        if (grant) begin
            n = (logout_at >= 0 && logout_at < SESS) ? logout_at + 1 : SESS;
            exp_expired = !(logout_at >= 0 && logout_at < SESS);
            for (int i = 0; i < n; i++) begin
                if (i == abort_at) begin
                    do_reset();
                    return;
                end
                chk("sess_active", 32'(session_active), 32'd1);
                chk("active_func", 32'(active_func), 32'(f));
                chk("no_early_expire", 32'(session_expired), 32'd0);
                chk("fail_cleared", 32'(fail_count), 32'd0);
                logout    = (i == logout_at);
                req_valid = 1'($urandom);
                @(negedge clk);
            end
            logout = 1'b0;
            req_valid = 1'b0;
            model_fails = 0;
            chk("sess_closed", 32'(session_active), 32'd0);
            chk("func_cleared", 32'(active_func), 32'd0);
            chk("expired_pulse", 32'(session_expired), 32'(exp_expired));
            chk("ready_after_sess", 32'(req_ready), 32'd1);
            @(negedge clk);
            chk("expired_one_cycle", 32'(session_expired), 32'd0);
            chk("still_idle", 32'(req_ready), 32'd1);
        end else begin
            chk("denied_pulse", 32'(denied), 32'd1);
            chk("deny_no_session", 32'(session_active), 32'd0);
            chk("deny_func_zero", 32'(active_func), 32'd0);
            model_fails++;
            @(negedge clk);
            chk("denied_one_cycle", 32'(denied), 32'd0);
            if (model_fails >= MAXF) begin
                chk("lock_fail_count", 32'(fail_count), 32'(MAXF));
                for (int i = 0; i < LOCK; i++) begin
                    if (i == abort_at) begin
                        do_reset();
                        return;
                    end
                    chk("locked", 32'(locked), 32'd1);
                    chk("ready_in_lock", 32'(req_ready), 32'd0);
                    req_valid = 1'($urandom);
                    user_id   = 3'd5;
                    func_req  = 3'd7;
                    @(negedge clk);
                end
                req_valid = 1'b0;
                model_fails = 0;
                chk("unlocked", 32'(locked), 32'd0);
                chk("fail_count_after_lock", 32'(fail_count), 32'd0);
                chk("ready_after_lock", 32'(req_ready), 32'd1);
            end else begin
                chk("fail_count", 32'(fail_count), 32'(model_fails));
                chk("ready_after_deny", 32'(req_ready), 32'd1);
                chk("not_locked", 32'(locked), 32'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        user_id   = 3'd0;
        func_req  = 3'd0;
        logout    = 1'b0;
        #1;
        chk("reset_sess_active", 32'(session_active), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_active_func", 32'(active_func), 32'd0);
        chk("reset_denied", 32'(denied), 32'd0);
        chk("reset_expired", 32'(session_expired), 32'd0);
        chk("reset_fail_count", 32'(fail_count), 32'd0);

        // Full session ending by timeout.
        do_req(3'd5, 3'd7, -1, -1);
        // Logout on the 5th granted cycle.
        do_req(3'd3, 3'd2, 4, -1);
        // Logout on the final granted cycle beats the timeout.
        do_req(3'd6, 3'd1, SESS - 1, -1);
        // Denial then a grant clears the fail count.
        do_req(3'd6, 3'd2, -1, -1);
        do_req(3'd6, 3'd6, 2, -1);
        // Three consecutive denials lock the panel.
        do_req(3'd4, 3'd1, -1, -1);
        do_req(3'd2, 3'd3, -1, -1);
        do_req(3'd3, 3'd5, -1, -1);
        // FN_NONE is always refused.
        do_req(3'd1, 3'd0, -1, -1);
        // Reset during a session, then during a lockout.
        do_req(3'd5, 3'd6, -1, 3);
        do_req(3'd0, 3'd1, -1, -1);
        do_req(3'd0, 3'd2, -1, -1);
        do_req(3'd7, 3'd3, -1, 10);

        for (int t = 0; t < 60; t++) begin
            logic [2:0] ru;
            logic [2:0] rf;
            int lo;
            ru = 3'($urandom);
            rf = 3'($urandom);
            lo = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, SESS - 1));
            do_req(ru, rf, lo, -1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
